// File: rtl/umul_bi_vec.sv
// umul_bi_vec: multi-channel bipolar unary multiplier with buffered weights and framed runs.
// Optional signed per-channel accumulators are built when UMUL_BI_VEC_ACC_EN is defined.

module umul_bi_vec_sobolrng #(
    parameter int BITWIDTH = 8
) (
    input  logic                iClk,
    input  logic                iRstN,
    input  logic                clr,
    input  logic                en,
    output logic [BITWIDTH-1:0] seq
);
    logic [BITWIDTH-1:0] cnt_r;
    logic [BITWIDTH-1:0] seq_r;
    logic [BITWIDTH-1:0] zmask_s;
    logic [BITWIDTH-1:0] dir_s;

    // The lowest zero of the step counter selects the direction vector (bit-reversed one-hot)
    always_comb begin
        zmask_s = ~cnt_r & (cnt_r + BITWIDTH'(1));
        dir_s   = {BITWIDTH{1'b0}};
        for (int i = 0; i < BITWIDTH; i++) begin
            dir_s[i] = zmask_s[BITWIDTH-1-i];
        end
    end

    // Sequence state; clear takes priority over stepping
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            cnt_r <= {BITWIDTH{1'b0}};
            seq_r <= {BITWIDTH{1'b0}};
        end else if (clr) begin
            cnt_r <= {BITWIDTH{1'b0}};
            seq_r <= {BITWIDTH{1'b0}};
        end else if (en) begin
            cnt_r <= cnt_r + BITWIDTH'(1);
            seq_r <= seq_r ^ dir_s;
        end else begin
            cnt_r <= cnt_r;
            seq_r <= seq_r;
        end
    end

    assign seq = seq_r;
endmodule

module umul_bi_vec #(
    parameter int BITWIDTH = 8,
    parameter int NUM_CH   = 4,
    parameter int LEN_LOG2 = 8
) (
    input  logic                             iClk,
    input  logic                             iRstN,
    input  logic [NUM_CH-1:0]                iA,
    input  logic [NUM_CH*BITWIDTH-1:0]       iB,
    input  logic                             iLoadValid,
    output logic                             oLoadReady,
    input  logic                             iStart,
    input  logic                             iClr,
    output logic [NUM_CH-1:0]                oMult,
    output logic                             oValid,
    output logic                             oBusy,
    output logic                             oDone,
    output logic [NUM_CH*(LEN_LOG2+2)-1:0]   oAcc
);
    localparam int AW = LEN_LOG2 + 2;
    localparam logic [LEN_LOG2-1:0] CNT_LAST = {LEN_LOG2{1'b1}};
    localparam logic [LEN_LOG2-1:0] CNT_PEN  = CNT_LAST - LEN_LOG2'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOADED = 2'd1,
        ST_RUN    = 2'd2
    } state_t;

    state_t              state_r;
    logic [LEN_LOG2-1:0] cnt_r;
    logic                ready_r;
    logic                busy_r;
    logic                done_r;
    logic [BITWIDTH-1:0] w_r [NUM_CH];

    logic                run_s;
    logic                load_fire_s;
    logic                start_s;
    logic                rng_clr_s;
    logic [NUM_CH-1:0]   mult_s;

    assign run_s       = (state_r == ST_RUN);
    assign load_fire_s = iLoadValid & ready_r & ~iClr;
    // A load in the same cycle as start wins; the start is dropped
    assign start_s     = (state_r == ST_LOADED) & iStart & ~iLoadValid & ~iClr;
    assign rng_clr_s   = start_s | iClr;

    // Run-control FSM with registered status flags
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            state_r <= ST_IDLE;
            cnt_r   <= {LEN_LOG2{1'b0}};
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else if (iClr) begin
            state_r <= ST_IDLE;
            cnt_r   <= {LEN_LOG2{1'b0}};
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (load_fire_s) begin
                        state_r <= ST_LOADED;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_LOADED: begin
                    if (start_s) begin
                        state_r <= ST_RUN;
                        cnt_r   <= {LEN_LOG2{1'b0}};
                        ready_r <= 1'b0;
                        busy_r  <= 1'b1;
                        done_r  <= 1'b0;
                    end else begin
                        state_r <= ST_LOADED;
                    end
                end
                ST_RUN: begin
                    cnt_r <= cnt_r + LEN_LOG2'(1);
                    if (cnt_r == CNT_LAST) begin
                        state_r <= ST_LOADED;
                        ready_r <= 1'b1;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b0;
                    end else begin
                        state_r <= ST_RUN;
                        done_r  <= (cnt_r == CNT_PEN);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= {LEN_LOG2{1'b0}};
                    ready_r <= 1'b1;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    // Weight buffer; cleared by abort, overwritten on every accepted load
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            for (int c = 0; c < NUM_CH; c++) begin
                w_r[c] <= {BITWIDTH{1'b0}};
            end
        end else if (iClr) begin
            for (int c = 0; c < NUM_CH; c++) begin
                w_r[c] <= {BITWIDTH{1'b0}};
            end
        end else if (load_fire_s) begin
            for (int c = 0; c < NUM_CH; c++) begin
                w_r[c] <= iB[c*BITWIDTH +: BITWIDTH];
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                w_r[c] <= w_r[c];
            end
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [BITWIDTH-1:0] top_seq_s;
        logic [BITWIDTH-1:0] bot_seq_s;

        umul_bi_vec_sobolrng #(.BITWIDTH(BITWIDTH)) u_top (
            .iClk  (iClk),
            .iRstN (iRstN),
            .clr   (rng_clr_s),
            .en    (run_s & ~iA[c]),
            .seq   (top_seq_s)
        );

        umul_bi_vec_sobolrng #(.BITWIDTH(BITWIDTH)) u_bot (
            .iClk  (iClk),
            .iRstN (iRstN),
            .clr   (rng_clr_s),
            .en    (run_s & iA[c]),
            .seq   (bot_seq_s)
        );

        // A zero input bit encodes -1, so the top path emits the complement of the comparison
        assign mult_s[c] = run_s & ((~iA[c] & ~(w_r[c] > top_seq_s)) |
                                    ( iA[c] &  (w_r[c] > bot_seq_s)));
    end

    assign oMult      = mult_s;
    assign oValid     = busy_r;
    assign oBusy      = busy_r;
    assign oLoadReady = ready_r;
    assign oDone      = done_r & ~iClr;

`ifdef UMUL_BI_VEC_ACC_EN
    logic [AW-1:0] acc_r [NUM_CH];

    // Two's-complement bipolar running sum, restarted on each run
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            for (int c = 0; c < NUM_CH; c++) begin
                acc_r[c] <= {AW{1'b0}};
            end
        end else if (iClr || start_s) begin
            for (int c = 0; c < NUM_CH; c++) begin
                acc_r[c] <= {AW{1'b0}};
            end
        end else if (run_s) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (mult_s[c]) begin
                    acc_r[c] <= acc_r[c] + AW'(1);
                end else begin
                    acc_r[c] <= acc_r[c] - AW'(1);
                end
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                acc_r[c] <= acc_r[c];
            end
        end
    end

    // Pack accumulators onto the flat output bus
    always_comb begin
        oAcc = {(NUM_CH*AW){1'b0}};
        for (int c = 0; c < NUM_CH; c++) begin
            oAcc[c*AW +: AW] = acc_r[c];
        end
    end
`else
    assign oAcc = {(NUM_CH*AW){1'b0}};
`endif

endmodule

// File: tb/tb_umul_bi_vec.sv
// Randomized self-checking bench for umul_bi_vec against a sequence-level reference model.
// The accumulator expectations follow UMUL_BI_VEC_ACC_EN.

module tb_umul_bi_vec;
    localparam int BW  = 8;
    localparam int NCH = 4;
    localparam int LL  = 8;
    localparam int AW  = LL + 2;
    localparam int RUN_LEN = 1 << LL;

    logic                  iClk;
    logic                  iRstN;
    logic [NCH-1:0]        iA;
    logic [NCH*BW-1:0]     iB;
    logic                  iLoadValid;
    logic                  oLoadReady;
    logic                  iStart;
    logic                  iClr;
    logic [NCH-1:0]        oMult;
    logic                  oValid;
    logic                  oBusy;
    logic                  oDone;
    logic [NCH*AW-1:0]     oAcc;

    umul_bi_vec #(.BITWIDTH(BW), .NUM_CH(NCH), .LEN_LOG2(LL)) dut (
        .iClk       (iClk),
        .iRstN      (iRstN),
        .iA         (iA),
        .iB         (iB),
        .iLoadValid (iLoadValid),
        .oLoadReady (oLoadReady),
        .iStart     (iStart),
        .iClr       (iClr),
        .oMult      (oMult),
        .oValid     (oValid),
        .oBusy      (oBusy),
        .oDone      (oDone),
        .oAcc       (oAcc)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    int n_checks = 0;
    int n_fail   = 0;

    // model: 0 = idle, 1 = weights held, 2 = running
    int           m_mode;
    int           m_k;
    logic [BW-1:0] m_w [NCH];
    int           m_top [NCH];
    int           m_bot [NCH];
    int           m_acc [NCH];

    logic [NCH-1:0] last_mult;
    logic           last_done;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // k-th point of the first Sobol dimension: bit-reversed Gray code of k
    function automatic logic [BW-1:0] sob(input int k);
        logic [BW-1:0] g;
        logic [BW-1:0] r;
        g = BW'(k ^ (k >> 1));
        for (int i = 0; i < BW; i++) r[i] = g[BW-1-i];
        return r;
    endfunction

    function automatic logic [NCH-1:0] model_mult(input logic [NCH-1:0] a);
        logic [NCH-1:0] m;
        m = '0;
        if (m_mode == 2) begin
            for (int c = 0; c < NCH; c++) begin
                if (a[c]) m[c] = (m_w[c] > sob(m_bot[c]));
                else      m[c] = !(m_w[c] > sob(m_top[c]));
            end
        end
        return m;
    endfunction

    task automatic model_reset();
        m_mode = 0;
        m_k = 0;
        for (int c = 0; c < NCH; c++) begin
            m_w[c] = '0; m_top[c] = 0; m_bot[c] = 0; m_acc[c] = 0;
        end
    endtask

    task automatic compare_outputs(input logic [NCH-1:0] a, input logic cl);
        logic [NCH*AW-1:0] ea;
        ea = '0;
`ifdef UMUL_BI_VEC_ACC_EN
        for (int c = 0; c < NCH; c++) ea[c*AW +: AW] = AW'(m_acc[c]);
`endif
        check_val("mult",  64'(oMult),      64'(model_mult(a)));
        check_val("valid", 64'(oValid),     64'(m_mode == 2));
        check_val("busy",  64'(oBusy),      64'(m_mode == 2));
        check_val("ready", 64'(oLoadReady), 64'(m_mode != 2));
        check_val("done",  64'(oDone),      64'(m_mode == 2 && m_k == RUN_LEN-1 && !cl));
        check_val("acc",   64'(oAcc),       64'(ea));
    endtask

    // One clock: drive, check at the falling edge, advance the model, then step
    task automatic tick(input logic [NCH-1:0] a, input logic [NCH*BW-1:0] b,
                        input logic lv, input logic st, input logic cl);
        logic [NCH-1:0] em;
        iA = a; iB = b; iLoadValid = lv; iStart = st; iClr = cl;
        @(negedge iClk);
        compare_outputs(a, cl);
        last_mult = oMult;
        last_done = oDone;
        em = model_mult(a);
        if (cl) begin
            model_reset();
        end else if (m_mode == 0) begin
            if (lv) begin
                for (int c = 0; c < NCH; c++) m_w[c] = b[c*BW +: BW];
                m_mode = 1;
            end
        end else if (m_mode == 1) begin
            if (lv) begin
                for (int c = 0; c < NCH; c++) m_w[c] = b[c*BW +: BW];
            end else if (st) begin
                m_mode = 2; m_k = 0;
                for (int c = 0; c < NCH; c++) begin
                    m_top[c] = 0; m_bot[c] = 0; m_acc[c] = 0;
                end
            end
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (a[c]) m_bot[c]++;
                else      m_top[c]++;
                m_acc[c] += em[c] ? 1 : -1;
            end
            if (m_k == RUN_LEN-1) m_mode = 1;
            m_k++;
        end
        @(posedge iClk);
        #1;
    endtask

    initial begin
        logic [NCH*BW-1:0] wv;
        logic [NCH-1:0]    aseq [RUN_LEN];
        int ones [NCH];
        int done_cnt;
        int done_idx;

        iRstN = 1'b0; iA = '0; iB = '0; iLoadValid = 1'b0; iStart = 1'b0; iClr = 1'b0;
        model_reset();
        @(posedge iClk); #1;
        compare_outputs('0, 1'b0);
        @(posedge iClk); #1;
        iRstN = 1'b1;

        // Directed: w = {77, 128, 0, 255}, iA = {1, 0, 1, 1} held for a whole run
        wv = {8'd77, 8'd128, 8'd0, 8'd255};
        tick(4'b1011, wv, 1'b1, 1'b0, 1'b0);
        tick(4'b1011, wv, 1'b0, 1'b1, 1'b0);
        for (int c = 0; c < NCH; c++) ones[c] = 0;
        done_cnt = 0; done_idx = -1;
        for (int i = 0; i < RUN_LEN; i++) begin
            tick(4'b1011, wv, 1'b0, 1'b0, 1'b0);
            for (int c = 0; c < NCH; c++) ones[c] += int'(last_mult[c]);
            if (last_done) begin done_cnt++; done_idx = i; end
        end
        check_val("ones_w255", 64'(ones[0]), 64'd255);
        check_val("ones_w0",   64'(ones[1]), 64'd0);
        check_val("ones_w128", 64'(ones[2]), 64'd128);
        check_val("ones_w77",  64'(ones[3]), 64'd77);
        check_val("done_count", 64'(done_cnt), 64'd1);
        check_val("done_index", 64'(done_idx), 64'd255);
        check_val("busy_after_run", 64'(oBusy), 64'd0);
`ifdef UMUL_BI_VEC_ACC_EN
        check_val("acc0_final", 64'(oAcc[0*AW +: AW]), 64'(10'sd254));
        check_val("acc1_final", 64'(oAcc[1*AW +: AW]), 64'(-10'sd256));
        check_val("acc2_final", 64'(oAcc[2*AW +: AW]), 64'(10'sd0));
`else
        check_val("acc_tied", 64'(oAcc), 64'd0);
`endif

        // Start together with load: load wins, then a lone start runs the new weights
        wv = $urandom;
        tick(4'b0000, wv, 1'b1, 1'b1, 1'b0);
        check_val("busy_after_load_start", 64'(oBusy), 64'd0);
        tick(4'b0000, wv, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < RUN_LEN; i++) tick(4'($urandom), wv, 1'b0, 1'b0, 1'b0);

        // Two runs with the same input stream; loads offered during the runs are refused
        wv = $urandom;
        tick(4'b0000, wv, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < RUN_LEN; i++) aseq[i] = 4'($urandom);
        for (int r = 0; r < 2; r++) begin
            tick(4'b0000, wv, 1'b0, 1'b1, 1'b0);
            for (int i = 0; i < RUN_LEN; i++)
                tick(aseq[i], $urandom, 1'($urandom_range(0, 3) == 0), 1'($urandom), 1'b0);
        end

        // Abort at run cycle 100, then a start from idle is ignored
        tick(4'b0000, wv, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 100; i++) tick(4'($urandom), wv, 1'b0, 1'b0, 1'b0);
        tick(4'($urandom), wv, 1'b0, 1'b0, 1'b1);
        check_val("busy_after_clr", 64'(oBusy), 64'd0);
        check_val("mult_after_clr", 64'(oMult), 64'd0);
        tick(4'b1111, wv, 1'b0, 1'b1, 1'b0);
        tick(4'b1111, wv, 1'b0, 1'b0, 1'b0);
        check_val("start_from_idle", 64'(oBusy), 64'd0);

        // Random traffic
        for (int i = 0; i < 1500; i++)
            tick(4'($urandom), $urandom, 1'($urandom_range(0, 19) == 0),
                 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 399) == 0));

        // Reset asserted mid-run returns to reset values at once
        tick(4'b0000, wv, 1'b1, 1'b0, 1'b0);
        tick(4'b0000, wv, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 50; i++) tick(4'($urandom), wv, 1'b0, 1'b0, 1'b0);
        iRstN = 1'b0;
        model_reset();
        #1;
        compare_outputs(iA, 1'b0);
        @(posedge iClk); #1;
        iRstN = 1'b1;
        for (int i = 0; i < 4; i++) tick(4'($urandom), wv, 1'b0, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
